// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues sequential word fetches over req/gnt/rvalid,
// tags responses with their PCs and buffers them in a small FIFO for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_if_take_branch,
  input  logic [31:0] ex_if_branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] kill;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_rd, fifo_wr;
  logic [AW-1:0] pcq_rd, pcq_wr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   pcq        [FIFO_DEPTH];

  logic          issue, killed_rsp, push, pop;
  logic [CW:0]   credit_used;
  logic          unused_tgt_lsbs;

  assign unused_tgt_lsbs = ^ex_if_branch_target[1:0];

  // Handshakes: a fetch transfers on a cycle with imem_req && imem_gnt; imem_addr
  // is stable while imem_req is high. Responses (imem_rvalid) return in grant
  // order and cannot be back-pressured. Decode takes the head on if_id_valid && !stall.
  always_comb begin
    credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    imem_req    = !rst && !ex_if_take_branch && (credit_used < DEPTH_W);
    issue       = imem_req && imem_gnt;
    killed_rsp  = imem_rvalid && (kill != '0);
    push        = imem_rvalid && (kill == '0) && !ex_if_take_branch;
    pop         = if_id_valid && !stall;
  end

  assign imem_addr   = fetch_pc;
  assign if_id_valid = (fifo_count != '0);
  assign if_id_instr = fifo_instr[fifo_rd];
  assign if_id_pc    = fifo_pc[fifo_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill        <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
        pcq[i]        <= '0;
      end
    end else if (ex_if_take_branch) begin
      // Everything still in flight after this cycle's response must be dropped.
      fetch_pc    <= {ex_if_branch_target[31:2], 2'b00};
      outstanding <= outstanding - CW'(imem_rvalid);
      kill        <= outstanding - CW'(imem_rvalid);
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        pcq[pcq_wr] <= fetch_pc;
        pcq_wr      <= pcq_wr + 1'b1;
      end
      outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);
      if (killed_rsp) kill <= kill - 1'b1;
      if (push) begin
        fifo_instr[fifo_wr] <= imem_rdata;
        fifo_pc[fifo_wr]    <= pcq[pcq_rd];
        fifo_wr             <= fifo_wr + 1'b1;
        pcq_rd              <= pcq_rd + 1'b1;
      end
      if (pop) fifo_rd <= fifo_rd + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  // The credit rule makes a push into a full buffer impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle vector table, a wrap-around reset PC instance,
// and a randomized memory/stall/redirect run checked against the sequential stream.
module tb_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br, gnt, rvalid;
  logic [31:0] tgt, rdata;
  logic        req, valid;
  logic [31:0] addr, instr, pc;

  logic        w_rst, w_stall, w_br, w_gnt, w_rvalid;
  logic [31:0] w_tgt, w_rdata;
  logic        w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc;

  fetch_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_if_take_branch(br), .ex_if_branch_target(tgt),
    .imem_req(req), .imem_addr(addr), .imem_gnt(gnt),
    .imem_rvalid(rvalid), .imem_rdata(rdata),
    .if_id_valid(valid), .if_id_instr(instr), .if_id_pc(pc)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall(w_stall),
    .ex_if_take_branch(w_br), .ex_if_branch_target(w_tgt),
    .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_gnt),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .if_id_valid(w_valid), .if_id_instr(w_instr), .if_id_pc(w_pc)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req, ca;
    logic [31:0] e_addr;
    logic        e_valid, cd;
    logic [31:0] e_pc, e_instr;
  } vec_t;

  function automatic vec_t vrow(
    input logic [31:0] a_rst, a_stall, a_br, a_tgt, a_gnt, a_rv, a_rva,
    input logic [31:0] a_req, a_ca, a_addr, a_valid, a_cd, a_pc, a_instr);
    vec_t r;
    r.rst = a_rst[0];   r.stall = a_stall[0]; r.br = a_br[0]; r.tgt = a_tgt;
    r.gnt = a_gnt[0];   r.rv = a_rv[0];
    r.rdata = a_rv[0] ? ins(a_rva) : 32'h0;
    r.e_req = a_req[0]; r.ca = a_ca[0]; r.e_addr = a_addr;
    r.e_valid = a_valid[0]; r.cd = a_cd[0]; r.e_pc = a_pc; r.e_instr = a_instr;
    return r;
  endfunction

  vec_t        vt[$];
  logic [31:0] exp_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] w_pend_addr;
    logic        w_pend;
    int          pops, max_out;

    rst = 1; stall = 0; br = 0; tgt = 0; gnt = 0; rvalid = 0; rdata = 0;
    w_rst = 1; w_stall = 0; w_br = 0; w_tgt = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0;

    //            rst st br tgt     gnt rv rva     req ca addr    val cd pc      instr
    vt.push_back(vrow(1, 0, 0, 0,      0, 0, 0,      0, 1, 'h0,   0, 1, 'h0,   'h0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h0,   0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h0,    1, 1, 'h4,   0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h4,    0, 0, 0,     1, 1, 'h0,   ins('h0)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h8,   1, 1, 'h4,   ins('h4)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h8,    1, 1, 'hC,   0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'hC,    0, 0, 0,     1, 1, 'h8,   ins('h8)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h10,  1, 1, 'hC,   ins('hC)));
    // stall holds the head while credits run out
    vt.push_back(vrow(0, 1, 0, 0,      1, 1, 'h10,   1, 1, 'h14,  0, 0, 0,     0));
    vt.push_back(vrow(0, 1, 0, 0,      1, 1, 'h14,   0, 0, 0,     1, 1, 'h10,  ins('h10)));
    vt.push_back(vrow(0, 1, 0, 0,      1, 0, 0,      0, 0, 0,     1, 1, 'h10,  ins('h10)));
    vt.push_back(vrow(0, 1, 0, 0,      1, 0, 0,      0, 0, 0,     1, 1, 'h10,  ins('h10)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      0, 0, 0,     1, 1, 'h10,  ins('h10)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h18,  1, 1, 'h14,  ins('h14)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h18,   1, 1, 'h1C,  0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      0, 0, 0,      0, 0, 0,     1, 1, 'h18,  ins('h18)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h20,  0, 0, 0,     0));
    // redirect with two fetches in flight: both responses dropped
    vt.push_back(vrow(0, 0, 1, 'h103,  1, 0, 0,      0, 0, 0,     0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h1C,   0, 1, 'h100, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h20,   1, 1, 'h100, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h100,  1, 1, 'h104, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h104,  0, 0, 0,     1, 1, 'h100, ins('h100)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h108, 1, 1, 'h104, ins('h104)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h108,  1, 1, 'h10C, 0, 0, 0,     0));
    // redirect during stall with a coincident response
    vt.push_back(vrow(0, 1, 0, 0,      1, 0, 0,      0, 0, 0,     1, 1, 'h108, ins('h108)));
    vt.push_back(vrow(0, 1, 1, 'h200,  1, 1, 'h10C,  0, 0, 0,     1, 1, 'h108, ins('h108)));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h200, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 1, 'h200,  1, 1, 'h204, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      0, 1, 'h204,  0, 0, 0,     1, 1, 'h200, ins('h200)));
    vt.push_back(vrow(0, 0, 0, 0,      0, 0, 0,      1, 1, 'h208, 1, 1, 'h204, ins('h204)));
    // redirect held for two cycles
    vt.push_back(vrow(0, 0, 1, 'h307,  1, 0, 0,      0, 0, 0,     0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 1, 'h307,  1, 0, 0,      0, 0, 0,     0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      1, 0, 0,      1, 1, 'h304, 0, 0, 0,     0));
    vt.push_back(vrow(0, 0, 0, 0,      0, 1, 'h304,  1, 1, 'h308, 0, 0, 0,     0));
    vt.push_back(vrow(0, 1, 0, 0,      0, 0, 0,      1, 1, 'h308, 1, 1, 'h304, ins('h304)));
    // reset mid-operation clears everything
    vt.push_back(vrow(1, 0, 0, 0,      1, 0, 0,      0, 0, 0,     1, 1, 'h304, ins('h304)));
    vt.push_back(vrow(0, 0, 0, 0,      0, 0, 0,      1, 1, 'h0,   0, 1, 'h0,   'h0));

    foreach (vt[i]) begin
      @(negedge clk);
      rst = vt[i].rst; stall = vt[i].stall; br = vt[i].br; tgt = vt[i].tgt;
      gnt = vt[i].gnt; rvalid = vt[i].rv; rdata = vt[i].rdata;
      #1;
      check($sformatf("v%0d imem_req", i), 32'(req), 32'(vt[i].e_req));
      if (vt[i].ca) check($sformatf("v%0d imem_addr", i), addr, vt[i].e_addr);
      check($sformatf("v%0d if_id_valid", i), 32'(valid), 32'(vt[i].e_valid));
      if (vt[i].cd) begin
        check($sformatf("v%0d if_id_pc", i), pc, vt[i].e_pc);
        check($sformatf("v%0d if_id_instr", i), instr, vt[i].e_instr);
      end
    end

    // Wrap-around of the fetch PC from a high reset address, zero-wait memory.
    exp_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    w_pend = 0; w_pend_addr = 0;
    @(negedge clk);
    w_rst = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      w_gnt = 1; w_rvalid = w_pend; w_rdata = ins(w_pend_addr);
      #1;
      if (w_valid) begin
        check("wrap pc", w_pc, exp_q[0]);
        check("wrap instr", w_instr, ins(exp_q[0]));
        void'(exp_q.pop_front());
      end
      w_pend = w_req && w_gnt;
      w_pend_addr = w_addr;
      @(negedge clk);
    end
    check("wrap stream drained", 32'(exp_q.size()), 32'd0);
    w_rst = 1; w_gnt = 0; w_rvalid = 0;

    // Randomized run: in-order memory with 1..4 cycle latency, random stall/redirect.
    rst = 1; stall = 0; br = 0; gnt = 0; rvalid = 0;
    @(negedge clk);
    rst = 0;
    exp_pc = 32'h0; pops = 0; max_out = 0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      stall = ($urandom_range(0, 3) == 0);
      br    = ($urandom_range(0, 39) == 0);
      tgt   = $urandom;
      gnt   = ($urandom_range(0, 3) != 0);
      if (mem_addr_q.size() > 0 && mem_due_q[0] <= c) begin
        rvalid = 1; rdata = ins(mem_addr_q[0]);
      end else begin
        rvalid = 0; rdata = $urandom;
      end
      #1;
      if (valid && !stall) begin
        check("rand pc", pc, exp_pc);
        check("rand instr", instr, ins(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      if (br) exp_pc = {tgt[31:2], 2'b00};
      if (req) check("rand addr align", 32'(addr[1:0]), 32'd0);
      if (rvalid) begin
        void'(mem_addr_q.pop_front());
        void'(mem_due_q.pop_front());
      end
      if (req && gnt) begin
        mem_addr_q.push_back(addr);
        mem_due_q.push_back(c + 1 + int'($urandom_range(0, 3)));
      end
      if (mem_addr_q.size() > max_out) max_out = mem_addr_q.size();
    end
    check("rand progress", 32'(pops > 1000), 32'd1);
    check("rand max outstanding", 32'(max_out <= 2), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
